// File: rtl/ravan_roundtrip_bist.sv
`default_nettype none
// ============================================================================
// Module   : ravan_roundtrip_bist
// Purpose  : Encrypt/decrypt round-trip self-test sequencer for the RAVAN core.
//            Optional macro RAVAN_BIST_SHA_GUARD_EN ends a run on core_sha_error.
// Revision : 1.0 - initial release
// ============================================================================
module ravan_roundtrip_bist #(
  parameter int                DATA_W       = 64,
  parameter int                KEY_W        = 512,
  parameter int                CORE_LATENCY = 10,
  parameter int                CNT_W        = 16,
  parameter logic [DATA_W-1:0] LFSR_TAPS    = 64'hD800000000000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_vectors,
  input  logic [DATA_W-1:0] seed,
  input  logic [KEY_W-1:0]  key_in,
  output logic              core_enc_op_sel,
  output logic [DATA_W-1:0] core_data_in,
  output logic [KEY_W-1:0]  core_key,
  input  logic [DATA_W-1:0] core_data_out,
  input  logic              core_sha_error,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  fail_count,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_data,
  output logic              aborted
);

  localparam int                LAT_W    = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(CORE_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ENC  = 3'd1,
    S_DEC  = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0] cipher_q, cipher_d;
  logic [DATA_W-1:0] dec_q, dec_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  nvec_q, nvec_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [CNT_W-1:0]  fail_count_q, fail_count_d;
  logic [CNT_W-1:0]  first_fail_idx_q, first_fail_idx_d;
  logic [DATA_W-1:0] first_fail_data_q, first_fail_data_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              aborted_q, aborted_d;

  logic              run_active;
  logic [CNT_W-1:0]  idx_inc;

  assign run_active = (state_q == S_ENC) || (state_q == S_DEC) || (state_q == S_CMP);
  assign idx_inc    = idx_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      lfsr_q            <= '0;
      cipher_q          <= '0;
      dec_q             <= '0;
      idx_q             <= '0;
      nvec_q            <= '0;
      key_q             <= '0;
      fail_count_q      <= '0;
      first_fail_idx_q  <= '0;
      first_fail_data_q <= '0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      aborted_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      lfsr_q            <= lfsr_d;
      cipher_q          <= cipher_d;
      dec_q             <= dec_d;
      idx_q             <= idx_d;
      nvec_q            <= nvec_d;
      key_q             <= key_d;
      fail_count_q      <= fail_count_d;
      first_fail_idx_q  <= first_fail_idx_d;
      first_fail_data_q <= first_fail_data_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
      aborted_q         <= aborted_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    lfsr_d            = lfsr_q;
    cipher_d          = cipher_q;
    dec_d             = dec_q;
    idx_d             = idx_q;
    nvec_d            = nvec_q;
    key_d             = key_q;
    fail_count_d      = fail_count_q;
    first_fail_idx_d  = first_fail_idx_q;
    first_fail_data_d = first_fail_data_q;
    done_d            = done_q;
    pass_d            = pass_q;
    aborted_d         = aborted_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          nvec_d            = num_vectors;
          key_d             = key_in;
          // An all-zero seed would lock the LFSR at zero.
          lfsr_d            = (seed == '0) ? '1 : seed;
          cnt_d             = '0;
          idx_d             = '0;
          fail_count_d      = '0;
          first_fail_idx_d  = '0;
          first_fail_data_d = '0;
          aborted_d         = 1'b0;
          if (num_vectors == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_ENC;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
      end
      S_ENC: begin
        if (cnt_q == LAT_LAST) begin
          cipher_d = core_data_out;
          cnt_d    = '0;
          state_d  = S_DEC;
        end else begin
          cnt_d = cnt_q + LAT_W'(1);
        end
      end
      S_DEC: begin
        if (cnt_q == LAT_LAST) begin
          dec_d   = core_data_out;
          cnt_d   = '0;
          state_d = S_CMP;
        end else begin
          cnt_d = cnt_q + LAT_W'(1);
        end
      end
      S_CMP: begin
        if (dec_q != lfsr_q) begin
          if (fail_count_q != '1) fail_count_d = fail_count_q + CNT_W'(1);
          if (fail_count_q == '0) begin
            first_fail_idx_d  = idx_q;
            first_fail_data_d = lfsr_q;
          end
        end
        lfsr_d = {1'b0, lfsr_q[DATA_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        idx_d  = idx_inc;
        if (idx_inc == nvec_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (fail_count_d == '0) && !aborted_q;
        end else begin
          state_d = S_ENC;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef RAVAN_BIST_SHA_GUARD_EN
    if (run_active && core_sha_error) begin
      state_d   = S_DONE;
      done_d    = 1'b1;
      pass_d    = 1'b0;
      aborted_d = 1'b1;
    end
`endif

    // Abort overrides everything, including a simultaneous SHA fault.
    if (run_active && abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end
  end

`ifndef RAVAN_BIST_SHA_GUARD_EN
  logic unused_sha_error;
  assign unused_sha_error = core_sha_error;
`endif

  always_comb begin
    core_enc_op_sel = 1'b0;
    core_data_in    = '0;
    if (state_q == S_ENC) begin
      core_enc_op_sel = 1'b1;
      core_data_in    = lfsr_q;
    end else if (state_q == S_DEC) begin
      core_data_in = cipher_q;
    end
  end

  assign core_key        = key_q;
  assign busy            = run_active;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail_count      = fail_count_q;
  assign first_fail_idx  = first_fail_idx_q;
  assign first_fail_data = first_fail_data_q;
`ifdef RAVAN_BIST_SHA_GUARD_EN
  assign aborted = aborted_q;
`else
  assign aborted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ravan_roundtrip_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_ravan_roundtrip_bist
// Purpose  : Bench for ravan_roundtrip_bist with an XOR core model and LFSR reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ravan_roundtrip_bist;

  localparam int           DATA_W  = 64;
  localparam int           KEY_W   = 512;
  localparam int           LAT     = 10;
  localparam int           CNT_W   = 16;
  localparam int           VEC_CYC = 2 * LAT + 1;
  localparam logic [63:0]  TAPS    = 64'hD800000000000000;
  localparam logic [511:0] KEY     = {{31{16'hA5A5}}, 16'hEEFD};
  localparam logic [63:0]  KEY_LO  = 64'hA5A5A5A5A5A5EEFD;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  num_vectors = '0;
  logic [DATA_W-1:0] seed = '0;
  logic [KEY_W-1:0]  key_in = KEY;
  logic              core_enc_op_sel;
  logic [DATA_W-1:0] core_data_in;
  logic [KEY_W-1:0]  core_key;
  logic [DATA_W-1:0] core_data_out;
  logic              core_sha_error = 1'b0;
  logic              busy, done, pass, aborted;
  logic [CNT_W-1:0]  fail_count, first_fail_idx;
  logic [DATA_W-1:0] first_fail_data;

  int n_checks = 0;
  int n_fails  = 0;
  logic [63:0] obs_pt[$];

  // Core model: XOR with key, optional single-bit corruption of one decrypt.
  logic        flip_on = 1'b0;
  logic [63:0] flip_cipher = '0;
  logic [63:0] pipe [LAT-1];

  ravan_roundtrip_bist dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_vectors(num_vectors), .seed(seed), .key_in(key_in),
    .core_enc_op_sel(core_enc_op_sel), .core_data_in(core_data_in),
    .core_key(core_key), .core_data_out(core_data_out),
    .core_sha_error(core_sha_error), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .first_fail_data(first_fail_data), .aborted(aborted)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] core_fn(input logic [63:0] din, input logic enc);
    logic [63:0] r;
    r = din ^ KEY_LO;
    if (flip_on && !enc && din == flip_cipher) r[0] = ~r[0];
    return r;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= core_fn(core_data_in, core_enc_op_sel);
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign core_data_out = pipe[LAT-2];

  function automatic logic [63:0] lfsr_next(input logic [63:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : 64'h0);
  endfunction

  function automatic logic [63:0] nth_pt(input logic [63:0] sd, input int k);
    logic [63:0] p;
    p = (sd == 64'h0) ? '1 : sd;
    for (int i = 0; i < k; i++) p = lfsr_next(p);
    return p;
  endfunction

  // Starts a run from a post-edge point and waits for done; cyc counts edges
  // from the cycle in which start was driven.
  task automatic run_vecs(input logic [15:0] n, input logic [63:0] sd,
                          output int cyc, output bit busy_seen);
    int   bound;
    logic prev_enc;
    bound = int'(n) * VEC_CYC + 30;
    obs_pt.delete();
    busy_seen = 1'b0;
    prev_enc  = 1'b0;
    num_vectors = n; seed = sd; key_in = KEY; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    forever begin
      if (busy) busy_seen = 1'b1;
      if (core_enc_op_sel && !prev_enc) obs_pt.push_back(core_data_in);
      prev_enc = core_enc_op_sel;
      if (done || cyc >= bound) break;
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++; if ({busy, done, pass, aborted, core_enc_op_sel} !== 5'b0) begin n_fails++; $display("FAIL reset_flags: got %b want 00000", {busy, done, pass, aborted, core_enc_op_sel}); end
    n_checks++; if (fail_count !== 16'h0 || first_fail_idx !== 16'h0) begin n_fails++; $display("FAIL reset_counts: got %h/%h want 0/0", fail_count, first_fail_idx); end
    n_checks++; if (first_fail_data !== 64'h0 || core_data_in !== 64'h0) begin n_fails++; $display("FAIL reset_data: got %h/%h want 0/0", first_fail_data, core_data_in); end
    n_checks++; if (core_key !== 512'h0) begin n_fails++; $display("FAIL reset_key: got %h want 0", core_key[63:0]); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc; bit bs; logic [63:0] p;
    run_vecs(16'd4, 64'h12345678ABCDEF01, cyc, bs);
    n_checks++; if (cyc !== 4 * VEC_CYC + 1) begin n_fails++; $display("FAIL t1_done_cycle: got %0d want %0d", cyc, 4 * VEC_CYC + 1); end
    n_checks++; if ({done, pass, busy, aborted} !== 4'b1100) begin n_fails++; $display("FAIL t1_flags: got %b want 1100", {done, pass, busy, aborted}); end
    n_checks++; if (fail_count !== 16'h0) begin n_fails++; $display("FAIL t1_fail_count: got %0d want 0", fail_count); end
    n_checks++; if (core_key !== KEY) begin n_fails++; $display("FAIL t1_key: got %h want %h", core_key[63:0], KEY_LO); end
    n_checks++; if (obs_pt.size() !== 4) begin n_fails++; $display("FAIL t1_vec_count: got %0d want 4", obs_pt.size()); end
    p = 64'h12345678ABCDEF01;
    for (int i = 0; i < obs_pt.size() && i < 4; i++) begin
      n_checks++; if (obs_pt[i] !== p) begin n_fails++; $display("FAIL t1_plaintext[%0d]: got %h want %h", i, obs_pt[i], p); end
      p = lfsr_next(p);
    end
  endtask

  task automatic test_fault();
    int cyc; bit bs; logic [63:0] p2;
    p2 = nth_pt(64'h12345678ABCDEF01, 2);
    flip_cipher = p2 ^ KEY_LO; flip_on = 1'b1;
    run_vecs(16'd4, 64'h12345678ABCDEF01, cyc, bs);
    flip_on = 1'b0;
    n_checks++; if (fail_count !== 16'd1) begin n_fails++; $display("FAIL t2_fail_count: got %0d want 1", fail_count); end
    n_checks++; if (first_fail_idx !== 16'd2) begin n_fails++; $display("FAIL t2_first_idx: got %0d want 2", first_fail_idx); end
    n_checks++; if (first_fail_data !== p2) begin n_fails++; $display("FAIL t2_first_data: got %h want %h", first_fail_data, p2); end
    n_checks++; if ({done, pass} !== 2'b10) begin n_fails++; $display("FAIL t2_done_pass: got %b want 10", {done, pass}); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    num_vectors = 16'd2; seed = 64'h0F0F_1234_5678_9ABC; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    n_checks++; if ({busy, done, pass} !== 3'b100) begin n_fails++; $display("FAIL b2b_restart_flags: got %b want 100", {busy, done, pass}); end
    n_checks++; if (fail_count !== 16'h0 || first_fail_idx !== 16'h0 || first_fail_data !== 64'h0) begin n_fails++; $display("FAIL b2b_cleared: got %h/%h/%h want 0/0/0", fail_count, first_fail_idx, first_fail_data); end
    while (!done && cyc < 200) begin @(posedge clk); #1; cyc++; end
    n_checks++; if (cyc !== 2 * VEC_CYC + 1 || pass !== 1'b1) begin n_fails++; $display("FAIL b2b_done: got cyc=%0d pass=%b want cyc=%0d pass=1", cyc, pass, 2 * VEC_CYC + 1); end
  endtask

  task automatic test_zero();
    int cyc; bit bs;
    run_vecs(16'd0, 64'hDEAD_BEEF_0000_0001, cyc, bs);
    n_checks++; if (cyc !== 1) begin n_fails++; $display("FAIL t3_done_cycle: got %0d want 1", cyc); end
    n_checks++; if ({done, pass} !== 2'b11) begin n_fails++; $display("FAIL t3_done_pass: got %b want 11", {done, pass}); end
    repeat (3) begin @(posedge clk); #1; if (busy) bs = 1'b1; end
    n_checks++; if (bs !== 1'b0) begin n_fails++; $display("FAIL t3_busy: got %b want 0", bs); end
  endtask

  task automatic test_abort();
    int cyc; logic [63:0] sd, c1;
    sd = 64'h0123_4567_89AB_CDEF;
    c1 = nth_pt(sd, 1) ^ KEY_LO;
    num_vectors = 16'd4; seed = sd; key_in = KEY; start = 1'b1; cyc = 0;
    while (cyc < 41) begin
      @(posedge clk); #1; cyc++;
      start = 1'b0; abort = 1'b0;
      if (cyc == 30) begin start = 1'b1; num_vectors = 16'd7; seed = ~sd; key_in = ~KEY; end
      if (cyc == 35) begin
        n_checks++; if ({busy, done} !== 2'b10) begin n_fails++; $display("FAIL t4_still_busy: got %b want 10", {busy, done}); end
        n_checks++; if (core_key !== KEY) begin n_fails++; $display("FAIL t4_key_held: got %h want %h", core_key[63:0], KEY_LO); end
        n_checks++; if (core_data_in !== c1 || core_enc_op_sel !== 1'b0) begin n_fails++; $display("FAIL t4_dec_vec1: got %h/%b want %h/0", core_data_in, core_enc_op_sel, c1); end
      end
      if (cyc == 40) abort = 1'b1;
    end
    key_in = KEY;
    n_checks++; if ({busy, done, pass} !== 3'b000) begin n_fails++; $display("FAIL t4_abort_flags: got %b want 000", {busy, done, pass}); end
    n_checks++; if (core_data_in !== 64'h0 || core_enc_op_sel !== 1'b0 || fail_count !== 16'h0) begin n_fails++; $display("FAIL t4_abort_idle: got %h/%b/%0d want 0/0/0", core_data_in, core_enc_op_sel, fail_count); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit bs;
    num_vectors = 16'd2; seed = 64'h5555_AAAA_0000_FFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({busy, done, pass, core_enc_op_sel} !== 4'b0) begin n_fails++; $display("FAIL t5_reset_flags: got %b want 0000", {busy, done, pass, core_enc_op_sel}); end
    n_checks++; if (core_key !== 512'h0 || core_data_in !== 64'h0) begin n_fails++; $display("FAIL t5_reset_data: got %h/%h want 0/0", core_key[63:0], core_data_in); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_vecs(16'd1, {$urandom, $urandom}, cyc, bs);
    n_checks++; if (cyc !== VEC_CYC + 1 || pass !== 1'b1) begin n_fails++; $display("FAIL t5_rerun: got cyc=%0d pass=%b want cyc=%0d pass=1", cyc, pass, VEC_CYC + 1); end
  endtask

  task automatic test_sha();
    int cyc;
    num_vectors = 16'd3; seed = 64'hFACE_CAFE_1357_2468; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    while (cyc < 25) begin @(posedge clk); #1; cyc++; end
    core_sha_error = 1'b1;
    @(posedge clk); #1; cyc++; core_sha_error = 1'b0;
`ifdef RAVAN_BIST_SHA_GUARD_EN
    n_checks++; if ({done, aborted, pass, busy} !== 4'b1100) begin n_fails++; $display("FAIL t6_guard: got %b want 1100", {done, aborted, pass, busy}); end
`else
    n_checks++; if ({busy, done} !== 2'b10) begin n_fails++; $display("FAIL t6_ignored: got %b want 10", {busy, done}); end
    while (!done && cyc < 200) begin @(posedge clk); #1; cyc++; end
    n_checks++; if (cyc !== 3 * VEC_CYC + 1 || {pass, aborted} !== 2'b10) begin n_fails++; $display("FAIL t6_complete: got cyc=%0d pass/aborted=%b want cyc=%0d 10", cyc, {pass, aborted}, 3 * VEC_CYC + 1); end
`endif
  endtask

  task automatic test_random();
    int cyc; bit bs; int n, k; logic [63:0] sd, pk;
    for (int it = 0; it < 5; it++) begin
      n  = $urandom_range(1, 5);
      k  = $urandom_range(0, 6);
      sd = (it == 0) ? 64'h0 : {$urandom, $urandom};
      pk = nth_pt(sd, k);
      flip_cipher = pk ^ KEY_LO; flip_on = 1'b1;
      run_vecs(16'(n), sd, cyc, bs);
      flip_on = 1'b0;
      n_checks++; if (cyc !== n * VEC_CYC + 1) begin n_fails++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", it, cyc, n * VEC_CYC + 1); end
      n_checks++; if (obs_pt.size() < 1 || obs_pt[0] !== nth_pt(sd, 0) || obs_pt[obs_pt.size()-1] !== nth_pt(sd, n - 1)) begin n_fails++; $display("FAIL rnd%0d_plaintext: got %0d vectors want %0d from seed %h", it, obs_pt.size(), n, sd); end
      if (k < n) begin
        n_checks++; if (fail_count !== 16'd1 || pass !== 1'b0) begin n_fails++; $display("FAIL rnd%0d_fail: got cnt=%0d pass=%b want cnt=1 pass=0", it, fail_count, pass); end
        n_checks++; if (first_fail_idx !== 16'(k) || first_fail_data !== pk) begin n_fails++; $display("FAIL rnd%0d_first: got %0d/%h want %0d/%h", it, first_fail_idx, first_fail_data, k, pk); end
      end else begin
        n_checks++; if (fail_count !== 16'd0 || pass !== 1'b1) begin n_fails++; $display("FAIL rnd%0d_clean: got cnt=%0d pass=%b want cnt=0 pass=1", it, fail_count, pass); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fault();
    test_back_to_back();
    test_zero();
    test_abort();
    test_reset_mid();
    test_sha();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
